ram_write_arbiter: RTL and testbench
====================================

# ram_write_arbiter

Parametrised, sequential successor to the combinational RAM-input selector. It accepts bursts from `NUM_CH` valid/ready sources, such as the layer input, file loader, decompressor and CNN write-back. It grants one source per burst and generates the RAM write strobe and address. It sits directly in front of the shared feature/image RAM write port and replaces fixed-select muxing with arbitration, burst locking, address generation and overflow detection.

## Interface
- `NUM_CH`, 4: number of source channels; channel 0 has the highest fixed priority.
- `DATA_W`, 8: data width per channel.
- `ADDR_W`, 16: RAM address width.
- `DEPTH`, 4096: RAM words; must be ≤ 2^`ADDR_W`.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Enable`  in  1  global write enable; when low, no handshakes occur.
- `BaseAddr`  in  `ADDR_W`  start address, sampled at grant.
- `ChValid`  in  `NUM_CH`  per-channel data valid.
- `ChLast`  in  `NUM_CH`  per-channel last beat of burst.
- `ChData`  in  `NUM_CH*DATA_W`  channel i occupies bits [i*DATA_W +: DATA_W].
- `ChReady`  out  `NUM_CH`  per-channel ready; one-hot or zero.
- `ToRAM`  out  `DATA_W`  registered write data.
- `RAMAddr`  out  `ADDR_W`  registered write address.
- `RAMWrite`  out  1  registered write strobe.
- `Grant`  out  `NUM_CH`  one-hot current owner; zero when idle.
- `Busy`  out  1  high in BURST or DONE.
- `Done`  out  1  one-cycle pulse at burst completion.
- `Overflow`  out  1  sticky; set when a burst runs past `DEPTH-1`.

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - If `Enable` is high and any `ChValid` is high, pick the winner and latch `Grant`.
  - Load the address counter with `BaseAddr`, then go to BURST.
  - No data transfers in this cycle.
- BURST:
  - `ChReady[g] = Enable`; all other `ChReady` bits are 0.
  - A beat transfers on a rising edge where `ChValid[g]` and `ChReady[g]` are both high.
  - Each beat registers `ToRAM`, `RAMAddr`, `RAMWrite=1` and increments the address counter.
  - Deasserting `Enable` pauses the burst; the state and counter hold.
- Burst end: a transfer with `ChLast[g]=1`, or a transfer at address `DEPTH-1`.
  - In the `DEPTH-1` case without `ChLast`, set `Overflow`. The address never wraps.
  - Move to DONE in either case.
- DONE: `Done=1` for one cycle, clear `Grant`, return to IDLE.
- `ChValid`, `ChLast` and `ChData` of non-granted channels are ignored.
- A granted channel that drops `ChValid` mid-burst stalls the burst without timeout.
- `RAMWrite` is 0 in every cycle not immediately following a transfer edge.
- Address arithmetic is unsigned `ADDR_W`-bit. `BaseAddr ≥ DEPTH` at grant is treated as overflow on the first beat.

## Timing
- Reset values: `ToRAM=0`, `RAMAddr=0`, `RAMWrite=0`, `Grant=0`, `ChReady=0`, `Busy=0`, `Done=0`, `Overflow=0`, state IDLE.
- `Reset` asserted mid-burst aborts immediately. No `Done` is produced and the partial data is discarded by the owner.
- Latency: a transfer at edge t gives `RAMWrite`, `ToRAM` and `RAMAddr` valid from t until t+1.
- Throughput: one beat per cycle within a burst.
- Burst overhead: one IDLE arbitration cycle plus one DONE cycle.
- `Done` coincides with the `RAMWrite` of the final beat.
- Simultaneous requests in IDLE are resolved by the arbitration policy (see Configuration).
- Requests arriving during BURST or DONE wait; they are not lost as long as `ChValid` is held.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The priority pointer starts at channel 0 after reset.
  - After each DONE, the pointer moves to (granted index + 1) mod `NUM_CH`.
  - The winner is the first requester at or after the pointer.
- `RAM_ARB_ROUND_ROBIN_EN` undefined: fixed priority; the lowest requesting index wins.

## Structure
- Shared package `ram_arb_pkg`:
  - FSM state enum (IDLE, BURST, DONE).
  - Default parameter constants.
  - A `clog2`-based index-width constant.
- Sub-module `ch_arbiter`:
  - Combinational picker: request vector plus pointer in, one-hot grant out.
  - Under the macro, a registered rotating pointer.

## Test plan
- Reset mid-burst:
  - Stimulus: ch2 three beats granted, `Reset` pulsed after beat 2.
  - Response: all outputs go to 0 immediately, no `Done`, and the next burst restarts from `BaseAddr`.
- Single channel:
  - Stimulus: `BaseAddr=0x10`, ch1 sends 4 beats 0xA0..0xA3 with `ChLast` on the 4th.
  - Response: `RAMWrite` for 4 consecutive cycles at addresses 0x10..0x13, `Done` on the 4th, `Overflow=0`.
- Contention:
  - Stimulus: ch0 and ch3 valid together, repeated for two bursts.
  - Response, fixed priority: ch0 granted first.
  - Response, `RAM_ARB_ROUND_ROBIN_EN`: ch0 wins the first burst and ch3 wins the second, even though ch0 is still requesting.
- Stall:
  - Stimulus: `Enable` low for 3 cycles, then `ChValid` low for 2 cycles, mid-burst.
  - Response: no `RAMWrite` and no address increment during the stalls; the burst resumes at the next address.
- Overflow:
  - Stimulus: `DEPTH=16`, `BaseAddr=14`, 5 beats with no `ChLast`.
  - Response: writes at 14 and 15 only, `Done` with beat 2, `Overflow=1` held until `Reset`.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types and default constants for the RAM write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int c_NUM_CH_DEF = 4;
    localparam int c_DATA_W_DEF = 8;
    localparam int c_ADDR_W_DEF = 16;
    localparam int c_DEPTH_DEF  = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arbState_t;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int c_IDX_W_DEF = idxWidth(c_NUM_CH_DEF);

endpackage

`default_nettype wire

// File: rtl/ram_write_arbiter_if.sv
// ============================================================================
// Module   : ram_write_arbiter_if
// Brief    : Source-side handshake and RAM write-port bundle of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_write_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int NUM_CH = c_NUM_CH_DEF,
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF
) ();

    logic                     Enable;
    logic [ADDR_W-1:0]        BaseAddr;
    logic [NUM_CH-1:0]        ChValid;
    logic [NUM_CH-1:0]        ChLast;
    logic [NUM_CH*DATA_W-1:0] ChData;
    logic [NUM_CH-1:0]        ChReady;
    logic [DATA_W-1:0]        ToRAM;
    logic [ADDR_W-1:0]        RAMAddr;
    logic                     RAMWrite;
    logic [NUM_CH-1:0]        Grant;
    logic                     Busy;
    logic                     Done;
    logic                     Overflow;

    modport master (
        output Enable, BaseAddr, ChValid, ChLast, ChData,
        input  ChReady, ToRAM, RAMAddr, RAMWrite, Grant, Busy, Done, Overflow
    );

    modport slave (
        input  Enable, BaseAddr, ChValid, ChLast, ChData,
        output ChReady, ToRAM, RAMAddr, RAMWrite, Grant, Busy, Done, Overflow
    );

endinterface

`default_nettype wire

// File: rtl/ch_arbiter.sv
// ============================================================================
// Module   : ch_arbiter
// Brief    : Picks the first requester at or after a priority pointer.
//            RAM_ARB_ROUND_ROBIN_EN: pointer rotates past each finished owner;
//            otherwise the pointer is fixed at channel 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ch_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_CH = c_NUM_CH_DEF,
    parameter int IDX_W  = idxWidth(NUM_CH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    input  logic [IDX_W-1:0]  i_lastIdx,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grantIdx
);

    logic [IDX_W-1:0] w_ptr;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (int'(i_lastIdx) == NUM_CH - 1) ? '0 : i_lastIdx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`else
    logic w_unused;
    assign w_unused = &{1'b0, Clk, Reset, i_advance, i_lastIdx};
    assign w_ptr    = '0;
`endif

    // Scan farthest-first so the nearest requester to the pointer wins.
    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (i_req[(int'(w_ptr) + k) % NUM_CH]) begin
                o_grant    = NUM_CH'(1) << ((int'(w_ptr) + k) % NUM_CH);
                o_grantIdx = IDX_W'((int'(w_ptr) + k) % NUM_CH);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_write_arbiter.sv
// ============================================================================
// Module   : ram_write_arbiter
// Brief    : Burst-locked arbiter and address generator for the RAM write port.
//            RAM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_write_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_CH = c_NUM_CH_DEF,
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF,
    parameter int DEPTH  = c_DEPTH_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    ram_write_arbiter_if.slave bus
);

    localparam int              c_IDX_W     = idxWidth(NUM_CH);
    localparam logic [ADDR_W:0] c_LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    arbState_t          r_state;
    arbState_t          w_nextState;
    logic [NUM_CH-1:0]  r_grant;
    logic [NUM_CH-1:0]  w_arbGrant;
    logic [c_IDX_W-1:0] r_grantIdx;
    logic [c_IDX_W-1:0] w_arbIdx;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_ramAddr;
    logic [DATA_W-1:0]  r_toRam;
    logic [DATA_W-1:0]  w_data;
    logic               r_ramWrite;
    logic               r_overflow;
    logic               w_start;
    logic               w_xfer;
    logic               w_last;
    logic               w_atEnd;
    logic               w_pastEnd;
    logic               w_burstEnd;
    logic               w_ovf;
    logic               w_advance;

    ch_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (c_IDX_W)
    ) u_chArbiter (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_req      (bus.ChValid),
        .i_advance  (w_advance),
        .i_lastIdx  (r_grantIdx),
        .o_grant    (w_arbGrant),
        .o_grantIdx (w_arbIdx)
    );

    assign w_advance  = (r_state == DONE);
    assign w_start    = (r_state == IDLE) && bus.Enable && (|bus.ChValid);
    assign w_xfer     = (r_state == BURST) && bus.Enable && (|(bus.ChValid & r_grant));
    assign w_last     = bus.ChLast[r_grantIdx];
    assign w_data     = bus.ChData[r_grantIdx*DATA_W +: DATA_W];
    assign w_atEnd    = ({1'b0, r_addr} == c_LAST_ADDR);
    assign w_pastEnd  = ({1'b0, r_addr} >  c_LAST_ADDR);
    assign w_burstEnd = w_last || w_atEnd || w_pastEnd;
    // Running off the end of the RAM without the source closing the burst.
    assign w_ovf      = w_pastEnd || (w_atEnd && !w_last);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = BURST;
            BURST:   if (w_xfer && w_burstEnd) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_addr     <= '0;
            r_ramAddr  <= '0;
            r_toRam    <= '0;
            r_ramWrite <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_ramWrite <= w_xfer;
            if (w_xfer) begin
                r_toRam   <= w_data;
                r_ramAddr <= r_addr;
                r_addr    <= r_addr + 1'b1;
            end
            if (w_xfer && w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_start) begin
                r_grant    <= w_arbGrant;
                r_grantIdx <= w_arbIdx;
                r_addr     <= bus.BaseAddr;
            end else if (w_xfer && w_burstEnd) begin
                r_grant <= '0;
            end
        end
    end

    assign bus.ChReady  = ((r_state == BURST) && bus.Enable) ? r_grant : '0;
    assign bus.ToRAM    = r_toRam;
    assign bus.RAMAddr  = r_ramAddr;
    assign bus.RAMWrite = r_ramWrite;
    assign bus.Grant    = r_grant;
    assign bus.Busy     = (r_state != IDLE);
    assign bus.Done     = (r_state == DONE);
    assign bus.Overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ram_write_arbiter.sv
// ============================================================================
// Module   : tb_ram_write_arbiter
// Brief    : Directed self-checking bench; honours RAM_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable;
    logic [15:0] baseAddr;
    logic [3:0]  chValid;
    logic [3:0]  chLast;
    logic [31:0] chData;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  expGrant2;
    logic [7:0]  expData2;

    ram_write_arbiter_if #(.NUM_CH(4), .DATA_W(8), .ADDR_W(16)) busA ();
    ram_write_arbiter_if #(.NUM_CH(4), .DATA_W(8), .ADDR_W(16)) busB ();

    assign busA.Enable   = enable;
    assign busA.BaseAddr = baseAddr;
    assign busA.ChValid  = chValid;
    assign busA.ChLast   = chLast;
    assign busA.ChData   = chData;
    assign busB.Enable   = enable;
    assign busB.BaseAddr = baseAddr;
    assign busB.ChValid  = chValid;
    assign busB.ChLast   = chLast;
    assign busB.ChData   = chData;

    ram_write_arbiter #(.NUM_CH(4), .DATA_W(8), .ADDR_W(16), .DEPTH(4096)) u_dutA (
        .Clk   (clk),
        .Reset (rst),
        .bus   (busA.slave)
    );

    ram_write_arbiter #(.NUM_CH(4), .DATA_W(8), .ADDR_W(16), .DEPTH(16)) u_dutB (
        .Clk   (clk),
        .Reset (rst),
        .bus   (busB.slave)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        enable   = 1'b0;
        baseAddr = '0;
        chValid  = '0;
        chLast   = '0;
        chData   = '0;

`ifdef RAM_ARB_ROUND_ROBIN_EN
        expGrant2 = 4'b1000;
        expData2  = 8'h33;
`else
        expGrant2 = 4'b0001;
        expData2  = 8'h11;
`endif

        // Reset state
        repeat (2) tick();
        checkEq("rst_toRam",    busA.ToRAM,    0);
        checkEq("rst_ramAddr",  busA.RAMAddr,  0);
        checkEq("rst_ramWrite", busA.RAMWrite, 0);
        checkEq("rst_grant",    busA.Grant,    0);
        checkEq("rst_chReady",  busA.ChReady,  0);
        checkEq("rst_busy",     busA.Busy,     0);
        checkEq("rst_done",     busA.Done,     0);
        checkEq("rst_overflow", busA.Overflow, 0);
        rst = 1'b0;

        // Single channel: ch1, four beats at 0x10..0x13
        enable        = 1'b1;
        baseAddr      = 16'h0010;
        chValid       = 4'b0010;
        chData[15:8]  = 8'hA0;
        tick();
        checkEq("sc_grant",  busA.Grant,    4'b0010);
        checkEq("sc_ready",  busA.ChReady,  4'b0010);
        checkEq("sc_arbWr",  busA.RAMWrite, 0);
        checkEq("sc_busy",   busA.Busy,     1);
        for (int i = 0; i < 4; i++) begin
            chData[15:8] = 8'hA0 + i[7:0];
            chLast[1]    = (i == 3);
            tick();
            checkEq("sc_wr",   busA.RAMWrite, 1);
            checkEq("sc_addr", busA.RAMAddr,  32'h10 + i);
            checkEq("sc_data", busA.ToRAM,    32'hA0 + i);
            checkEq("sc_done", busA.Done,     (i == 3) ? 32'd1 : 32'd0);
        end
        chValid = '0;
        chLast  = '0;
        tick();
        checkEq("sc_idleWr",  busA.RAMWrite, 0);
        checkEq("sc_idleDn",  busA.Done,     0);
        checkEq("sc_idleBsy", busA.Busy,     0);
        checkEq("sc_idleGnt", busA.Grant,    0);
        checkEq("sc_ovf",     busA.Overflow, 0);

        // Contention: ch0 and ch3, single-beat bursts, both held valid
        baseAddr       = 16'h0020;
        chData[7:0]    = 8'h11;
        chData[31:24]  = 8'h33;
        chLast         = 4'b1001;
        chValid        = 4'b1001;
        tick();
        checkEq("ct_grant1", busA.Grant,   4'b0001);
        checkEq("ct_ready1", busA.ChReady, 4'b0001);
        tick();
        checkEq("ct_data1",  busA.ToRAM,   8'h11);
        checkEq("ct_addr1",  busA.RAMAddr, 16'h0020);
        checkEq("ct_done1",  busA.Done,    1);
        tick();
        checkEq("ct_idle",   busA.Busy,    0);
        tick();
        checkEq("ct_grant2", busA.Grant,   expGrant2);
        tick();
        checkEq("ct_data2",  busA.ToRAM,   expData2);
        checkEq("ct_done2",  busA.Done,    1);
        chValid = '0;
        chLast  = '0;
        tick();

        // Stall: Enable low 3 cycles, then ChValid low 2 cycles
        baseAddr      = 16'h0040;
        chValid       = 4'b0100;
        chData[23:16] = 8'hC0;
        tick();
        tick();
        checkEq("st_addr0", busA.RAMAddr, 16'h0040);
        checkEq("st_data0", busA.ToRAM,   8'hC0);
        chData[23:16] = 8'hC1;
        enable        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkEq("st_enWr",  busA.RAMWrite, 0);
            checkEq("st_enRdy", busA.ChReady,  0);
            checkEq("st_enBsy", busA.Busy,     1);
        end
        enable  = 1'b1;
        chValid = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkEq("st_vldWr", busA.RAMWrite, 0);
        end
        chValid   = 4'b0100;
        chLast[2] = 1'b1;
        tick();
        checkEq("st_wr1",   busA.RAMWrite, 1);
        checkEq("st_addr1", busA.RAMAddr,  16'h0041);
        checkEq("st_data1", busA.ToRAM,    8'hC1);
        checkEq("st_done",  busA.Done,     1);
        chValid = '0;
        chLast  = '0;
        tick();

        // Reset mid-burst on ch2 after beat 2
        baseAddr      = 16'h0050;
        chValid       = 4'b0100;
        chData[23:16] = 8'hD0;
        tick();
        tick();
        chData[23:16] = 8'hD1;
        tick();
        checkEq("rm_addr1", busA.RAMAddr, 16'h0051);
        chData[23:16] = 8'hD2;
        #1 rst = 1'b1;
        #1;
        checkEq("rm_wr",    busA.RAMWrite, 0);
        checkEq("rm_grant", busA.Grant,    0);
        checkEq("rm_addr",  busA.RAMAddr,  0);
        checkEq("rm_data",  busA.ToRAM,    0);
        checkEq("rm_busy",  busA.Busy,     0);
        checkEq("rm_done",  busA.Done,     0);
        checkEq("rm_ready", busA.ChReady,  0);
        #1 rst = 1'b0;
        chLast[2] = 1'b1;
        tick();
        checkEq("rm_regrant", busA.Grant,    4'b0100);
        checkEq("rm_arbWr",   busA.RAMWrite, 0);
        tick();
        checkEq("rm_restart", busA.RAMAddr,  16'h0050);
        checkEq("rm_rdata",   busA.ToRAM,    8'hD2);
        checkEq("rm_rdone",   busA.Done,     1);
        chValid = '0;
        chLast  = '0;
        tick();

        // Overflow on the DEPTH=16 instance: BaseAddr 14, no ChLast
        rst = 1'b1;
        tick();
        checkEq("of_rstOvf", busB.Overflow, 0);
        rst           = 1'b0;
        baseAddr      = 16'd14;
        chValid       = 4'b0010;
        chData[15:8]  = 8'hE0;
        tick();
        checkEq("of_grant", busB.Grant, 4'b0010);
        tick();
        checkEq("of_wr0",   busB.RAMWrite, 1);
        checkEq("of_addr0", busB.RAMAddr,  16'd14);
        checkEq("of_done0", busB.Done,     0);
        checkEq("of_ovf0",  busB.Overflow, 0);
        chData[15:8] = 8'hE1;
        tick();
        checkEq("of_wr1",   busB.RAMWrite, 1);
        checkEq("of_addr1", busB.RAMAddr,  16'd15);
        checkEq("of_data1", busB.ToRAM,    8'hE1);
        checkEq("of_done1", busB.Done,     1);
        checkEq("of_ovf1",  busB.Overflow, 1);
        chValid      = '0;
        chData[15:8] = 8'hE2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkEq("of_noWr",  busB.RAMWrite, 0);
            checkEq("of_hold",  busB.Overflow, 1);
        end
        checkEq("of_noOvfA", busA.Overflow, 0);
        rst = 1'b1;
        tick();
        checkEq("of_clr", busB.Overflow, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
